// File: rtl/comp_out_framer.sv
// comp_out_framer: store-and-forward packet framer for the compressor output.
// Buffers one packet (up to DEPTH 64-bit words) and then emits a header word,
// the payload words and, when COMP_FRAMER_CHK_EN is defined, an XOR trailer.
// Optional feature macro: COMP_FRAMER_CHK_EN (adds the TRL state and checksum).
// Handshake: a beat moves on an edge where valid and ready are both high.
// The sender holds data and flags stable until that edge.
module comp_out_framer #(
    parameter int          DEPTH     = 32,
    parameter logic [15:0] HDR_MAGIC = 16'hA5C3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_i,
    input  logic        valid_i,
    input  logic        sop_i,
    input  logic        eop_i,
    output logic        ready_o,
    output logic [63:0] data_o,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    input  logic        ready_i,
    output logic [7:0]  seq_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HDR,
        S_DATA
`ifdef COMP_FRAMER_CHK_EN
        , S_TRL
`endif
    } state_t;

`ifdef COMP_FRAMER_CHK_EN
    localparam logic TFLAG = 1'b1;
`else
    localparam logic TFLAG = 1'b0;
`endif

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [CW-1:0] rd_ptr, rd_n;
    logic [7:0]    seq, seq_n;
    logic          err_q, err_n;
    logic          rdy_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          accept;
    logic          last_word;
    logic [6:0]    count_ext;
    logic [63:0]   mem [DEPTH];
`ifdef COMP_FRAMER_CHK_EN
    logic [63:0]   chk, chk_n;
`endif

    // rdy_en keeps ready_o low during reset and lets it rise on the first edge after
    assign ready_o   = rdy_en && ((state == S_IDLE) || (state == S_FILL));
    assign accept    = valid_i && ready_o;
    assign last_word = (rd_ptr == (count - CW'(1)));
    assign count_ext = 7'(count);
    assign seq_o     = seq;
    assign err_o     = err_q;

    // State and control registers; reset drops any packet in progress silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            rd_ptr <= '0;
            seq    <= '0;
            err_q  <= 1'b0;
            rdy_en <= 1'b0;
`ifdef COMP_FRAMER_CHK_EN
            chk    <= '0;
`endif
        end else begin
            state  <= state_n;
            count  <= count_n;
            rd_ptr <= rd_n;
            seq    <= seq_n;
            err_q  <= err_n;
            rdy_en <= 1'b1;
`ifdef COMP_FRAMER_CHK_EN
            chk    <= chk_n;
`endif
        end
    end

    // Packet buffer write port; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_i;
        end
    end

    // Next-state logic: fill the buffer, then walk header/payload/trailer
    always_comb begin
        state_n = state;
        count_n = count;
        rd_n    = rd_ptr;
        seq_n   = seq;
        err_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = count[AW-1:0];
`ifdef COMP_FRAMER_CHK_EN
        chk_n   = chk;
`endif
        case (state)
            S_IDLE: begin
                // Beats without sop are dropped here without an error
                if (accept && sop_i) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    count_n = CW'(1);
`ifdef COMP_FRAMER_CHK_EN
                    chk_n   = data_i;
`endif
                    state_n = eop_i ? S_HDR : S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (sop_i) begin
                        // New packet start abandons the partial one
                        err_n   = 1'b1;
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        count_n = CW'(1);
`ifdef COMP_FRAMER_CHK_EN
                        chk_n   = data_i;
`endif
                        state_n = eop_i ? S_HDR : S_FILL;
                    end else if (count == FULL) begin
                        // No room for another word: drop the whole packet
                        err_n   = 1'b1;
                        count_n = '0;
                        state_n = S_IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        count_n = count + CW'(1);
`ifdef COMP_FRAMER_CHK_EN
                        chk_n   = chk ^ data_i;
`endif
                        if (eop_i) begin
                            state_n = S_HDR;
                        end
                    end
                end
            end
            S_HDR: begin
                if (ready_i) begin
                    rd_n    = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (ready_i) begin
                    if (last_word) begin
`ifdef COMP_FRAMER_CHK_EN
                        state_n = S_TRL;
`else
                        seq_n   = seq + 8'd1;
                        count_n = '0;
                        state_n = S_IDLE;
`endif
                    end else begin
                        rd_n = rd_ptr + CW'(1);
                    end
                end
            end
`ifdef COMP_FRAMER_CHK_EN
            S_TRL: begin
                if (ready_i) begin
                    seq_n   = seq + 8'd1;
                    count_n = '0;
                    state_n = S_IDLE;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // Output mux: purely from registered state so it holds while stalled
    always_comb begin
        valid_o = 1'b0;
        sop_o   = 1'b0;
        eop_o   = 1'b0;
        data_o  = '0;
        case (state)
            S_HDR: begin
                valid_o = 1'b1;
                sop_o   = 1'b1;
                data_o  = {HDR_MAGIC, seq, 33'b0, TFLAG, count_ext[5:0]};
            end
            S_DATA: begin
                valid_o = 1'b1;
                data_o  = mem[rd_ptr[AW-1:0]];
                eop_o   = last_word && !TFLAG;
            end
`ifdef COMP_FRAMER_CHK_EN
            S_TRL: begin
                valid_o = 1'b1;
                eop_o   = 1'b1;
                data_o  = chk;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_comp_out_framer.sv
// Directed bench for comp_out_framer (DEPTH=32, HDR_MAGIC=16'hA5C3).
module tb_comp_out_framer;
    logic        clk;
    logic        rst;
    logic [63:0] data_i;
    logic        valid_i;
    logic        sop_i;
    logic        eop_i;
    logic        ready_o;
    logic [63:0] data_o;
    logic        valid_o;
    logic        sop_o;
    logic        eop_o;
    logic        ready_i;
    logic [7:0]  seq_o;
    logic        err_o;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_seq = 8'd0;
    logic [63:0] chk_acc = 64'd0;
    logic [65:0] exp_q[$];

`ifdef COMP_FRAMER_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    comp_out_framer #(.DEPTH(32), .HDR_MAGIC(16'hA5C3)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .sop_i(sop_i), .eop_i(eop_i), .ready_o(ready_o), .data_o(data_o),
        .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o), .ready_i(ready_i),
        .seq_o(seq_o), .err_o(err_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [7:0] s, input int c);
        logic [5:0] c6;
        c6 = 6'(c);
        return {16'hA5C3, s, 33'b0, CHK, c6};
    endfunction

    // expected-stream builders (no comparisons)
    task automatic push_hdr(input logic [7:0] s, input int c);
        exp_q.push_back({1'b1, 1'b0, hdr(s, c)});
        chk_acc = 64'd0;
    endtask

    task automatic push_word(input logic [63:0] d, input bit last);
        exp_q.push_back({1'b0, last && !CHK, d});
        chk_acc = chk_acc ^ d;
        if (last && CHK) exp_q.push_back({1'b0, 1'b1, chk_acc});
    endtask

    // driver: one input beat, returns 1 ns after the accepting edge
    task automatic send(input logic [63:0] d, input bit s, input bit e);
        valid_i = 1'b1; data_i = d; sop_i = s; eop_i = e;
        @(posedge clk); #1;
        valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid_i = 0; sop_i = 0; eop_i = 0; data_i = '0; ready_i = 1'b1;
        #2;
        checks++;
        if ({ready_o, valid_o, sop_o, eop_o, err_o, seq_o, data_o} !== 77'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b sop=%b eop=%b err=%b seq=%h data=%h, want all 0",
                     ready_o, valid_o, sop_o, eop_o, err_o, seq_o, data_o);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready_rise: got %b want 1", ready_o);
        end
    endtask

    task automatic test_basic;
        logic [65:0] e;
        push_hdr(exp_seq, 3);
        push_word(64'h1111_1111_1111_1111, 0);
        push_word(64'h2222_2222_2222_2222, 0);
        push_word(64'h3333_3333_3333_3333, 1);
        send(64'h1111_1111_1111_1111, 1, 0);
        send(64'h2222_2222_2222_2222, 0, 0);
        send(64'h3333_3333_3333_3333, 0, 1);
        checks++;
        if ({valid_o, sop_o, ready_o} !== 3'b110) begin
            errors++; $display("FAIL basic_latency: got v=%b sop=%b rdy=%b want 1 1 0", valid_o, sop_o, ready_o);
        end
        while (exp_q.size() > 0) begin
            for (int n = 0; n < 20 && valid_o !== 1'b1; n++) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            checks++;
            if ({valid_o, sop_o, eop_o, data_o} !== {1'b1, e}) begin
                errors++; $display("FAIL basic_beat: got v=%b sop=%b eop=%b data=%h want sop=%b eop=%b data=%h",
                                   valid_o, sop_o, eop_o, data_o, e[65], e[64], e[63:0]);
            end
            @(posedge clk); #1;
        end
        exp_seq = exp_seq + 8'd1;
        checks++;
        if ({valid_o, ready_o, seq_o} !== {2'b01, exp_seq}) begin
            errors++; $display("FAIL basic_end: got v=%b rdy=%b seq=%0d want 0 1 %0d", valid_o, ready_o, seq_o, exp_seq);
        end
    endtask

    task automatic test_single;
        logic [65:0] e;
        push_hdr(exp_seq, 1);
        push_word(64'hDEAD_BEEF_0000_0001, 1);
        send(64'hDEAD_BEEF_0000_0001, 1, 1);
        while (exp_q.size() > 0) begin
            for (int n = 0; n < 20 && valid_o !== 1'b1; n++) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            checks++;
            if ({valid_o, sop_o, eop_o, data_o} !== {1'b1, e}) begin
                errors++; $display("FAIL single_beat: got v=%b sop=%b eop=%b data=%h want sop=%b eop=%b data=%h",
                                   valid_o, sop_o, eop_o, data_o, e[65], e[64], e[63:0]);
            end
            @(posedge clk); #1;
        end
        exp_seq = exp_seq + 8'd1;
        checks++;
        if (seq_o !== exp_seq) begin
            errors++; $display("FAIL single_seq: got %0d want %0d", seq_o, exp_seq);
        end
    endtask

    task automatic test_overflow;
        logic [65:0] e;
        for (int i = 0; i < 32; i++) send(64'(i) + 64'h100, i == 0, 0);
        checks++;
        if ({err_o, valid_o} !== 2'b00) begin
            errors++; $display("FAIL overflow_full: got err=%b v=%b want 0 0", err_o, valid_o);
        end
        send(64'h133, 0, 0);
        checks++;
        if ({err_o, valid_o} !== 2'b10) begin
            errors++; $display("FAIL overflow_err: got err=%b v=%b want 1 0", err_o, valid_o);
        end
        send(64'h134, 0, 0);
        send(64'h135, 0, 1);
        checks++;
        if ({err_o, valid_o, seq_o} !== {2'b00, exp_seq}) begin
            errors++; $display("FAIL overflow_discard: got err=%b v=%b seq=%0d want 0 0 %0d", err_o, valid_o, seq_o, exp_seq);
        end
        push_hdr(exp_seq, 1);
        push_word(64'h0BAD_F00D_0000_0042, 1);
        send(64'h0BAD_F00D_0000_0042, 1, 1);
        while (exp_q.size() > 0) begin
            for (int n = 0; n < 20 && valid_o !== 1'b1; n++) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            checks++;
            if ({valid_o, sop_o, eop_o, data_o} !== {1'b1, e}) begin
                errors++; $display("FAIL overflow_next: got v=%b sop=%b eop=%b data=%h want sop=%b eop=%b data=%h",
                                   valid_o, sop_o, eop_o, data_o, e[65], e[64], e[63:0]);
            end
            @(posedge clk); #1;
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic test_restart;
        logic [65:0] e;
        send(64'hAAAA_0000_0000_0001, 1, 0);
        send(64'hAAAA_0000_0000_0002, 0, 0);
        send(64'hBBBB_0000_0000_0001, 1, 0);
        checks++;
        if ({err_o, valid_o} !== 2'b10) begin
            errors++; $display("FAIL restart_err: got err=%b v=%b want 1 0", err_o, valid_o);
        end
        send(64'hBBBB_0000_0000_0002, 0, 1);
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL restart_err_pulse: got %b want 0", err_o);
        end
        push_hdr(exp_seq, 2);
        push_word(64'hBBBB_0000_0000_0001, 0);
        push_word(64'hBBBB_0000_0000_0002, 1);
        while (exp_q.size() > 0) begin
            for (int n = 0; n < 20 && valid_o !== 1'b1; n++) begin @(posedge clk); #1; end
            e = exp_q.pop_front();
            checks++;
            if ({valid_o, sop_o, eop_o, data_o} !== {1'b1, e}) begin
                errors++; $display("FAIL restart_beat: got v=%b sop=%b eop=%b data=%h want sop=%b eop=%b data=%h",
                                   valid_o, sop_o, eop_o, data_o, e[65], e[64], e[63:0]);
            end
            @(posedge clk); #1;
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic test_backpressure;
        logic [63:0] w [3];
        logic [63:0] exp_d;
        int          idx;
        int          nitems;
        bit          rdy;
        w[0] = 64'h0123_4567_89AB_CDEF;
        w[1] = 64'hFEDC_BA98_7654_3210;
        w[2] = 64'h0F0F_0F0F_F0F0_F0F0;
        nitems = CHK ? 4 : 3;
        send(w[0], 1, 0);
        send(w[1], 0, 0);
        send(w[2], 0, 1);
        checks++;
        if ({valid_o, sop_o, data_o} !== {2'b11, hdr(exp_seq, 3)}) begin
            errors++; $display("FAIL bp_header: got v=%b sop=%b data=%h want 1 1 %h", valid_o, sop_o, data_o, hdr(exp_seq, 3));
        end
        @(posedge clk); #1;
        idx = 0;
        for (int k = 0; k < 24 && idx < nitems; k++) begin
            rdy = ((k % 4) == 0) || ((k % 4) == 3);
            ready_i = rdy;
            exp_d = (idx < 3) ? w[idx] : (w[0] ^ w[1] ^ w[2]);
            checks++;
            if ({valid_o, sop_o, eop_o, ready_o, data_o} !== {1'b1, 1'b0, idx == nitems - 1, 1'b0, exp_d}) begin
                errors++; $display("FAIL bp_hold: cycle %0d got v=%b sop=%b eop=%b rdy=%b data=%h want 1 0 %b 0 %h",
                                   k, valid_o, sop_o, eop_o, ready_o, data_o, idx == nitems - 1, exp_d);
            end
            @(posedge clk); #1;
            if (rdy) idx++;
        end
        ready_i = 1'b1;
        exp_seq = exp_seq + 8'd1;
        checks++;
        if ({valid_o, seq_o} !== {1'b0, exp_seq}) begin
            errors++; $display("FAIL bp_end: got v=%b seq=%0d want 0 %0d", valid_o, seq_o, exp_seq);
        end
    endtask

    task automatic test_reset_mid;
        send(64'h5555_0000_0000_0001, 1, 0);
        send(64'h5555_0000_0000_0002, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready_o, valid_o, sop_o, eop_o, err_o, seq_o, data_o} !== 77'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got rdy=%b v=%b sop=%b eop=%b err=%b seq=%h data=%h want all 0",
                               ready_o, valid_o, sop_o, eop_o, err_o, seq_o, data_o);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        exp_seq = 8'd0;
        checks++;
        if ({ready_o, err_o, seq_o} !== {2'b10, 8'd0}) begin
            errors++; $display("FAIL reset_mid_after: got rdy=%b err=%b seq=%0d want 1 0 0", ready_o, err_o, seq_o);
        end
        send(64'h5555_0000_0000_0003, 0, 1);
        @(posedge clk); #1;
        checks++;
        if ({valid_o, err_o} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_dropped: got v=%b err=%b want 0 0", valid_o, err_o);
        end
    endtask

    task automatic test_seq_wrap;
        logic [65:0] e;
        for (int i = 0; i < 256; i++) begin
            push_hdr(8'(i), 1);
            push_word(64'hC0DE_0000_0000_0000 | 64'(i), 1);
            send(64'hC0DE_0000_0000_0000 | 64'(i), 1, 1);
            while (exp_q.size() > 0) begin
                for (int n = 0; n < 20 && valid_o !== 1'b1; n++) begin @(posedge clk); #1; end
                e = exp_q.pop_front();
                checks++;
                if ({valid_o, sop_o, eop_o, data_o} !== {1'b1, e}) begin
                    errors++; $display("FAIL wrap_beat: pkt %0d got v=%b sop=%b eop=%b data=%h want sop=%b eop=%b data=%h",
                                       i, valid_o, sop_o, eop_o, data_o, e[65], e[64], e[63:0]);
                end
                @(posedge clk); #1;
            end
        end
        checks++;
        if (seq_o !== 8'd0) begin
            errors++; $display("FAIL wrap_seq: got %0d want 0", seq_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_restart();
        test_backpressure();
        test_reset_mid();
        test_seq_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
